alu_seq_ctrl: RTL and testbench

- Hardwired control sequencer for the datapath; produces per-step control strobes for fetch plus execute of register-register and register-immediate ALU instructions.
- Replaces hand-driven T0..T5 sequencing with a parametrised FSM.
- Memory wait states are configurable, and the ALU operation is selected from the IR opcode.
- Sits between IR and the datapath control inputs, one state per Clock.

---
 rtl/alu_seq_pkg.sv | 65 ++++++
 rtl/alu_seq_decode.sv | 30 +++
 rtl/alu_seq_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU instruction sequencer: state codes, opcode map,
// ALU function codes, instruction classes and the control-strobe bundle.
package alu_seq_pkg;

    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_T0   = 4'd1;
    localparam logic [3:0] ST_T1   = 4'd2;
    localparam logic [3:0] ST_T2   = 4'd3;
    localparam logic [3:0] ST_T3   = 4'd4;
    localparam logic [3:0] ST_T4   = 4'd5;
    localparam logic [3:0] ST_T5   = 4'd6;
    localparam logic [3:0] ST_HALT = 4'd7;

    typedef enum logic [3:0] {
        S_IDLE = ST_IDLE,
        S_T0   = ST_T0,
        S_T1   = ST_T1,
        S_T2   = ST_T2,
        S_T3   = ST_T3,
        S_T4   = ST_T4,
        S_T5   = ST_T5,
        S_HALT = ST_HALT
    } state_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;

    localparam logic [3:0] ALU_NOP = 4'd0;
    localparam logic [3:0] ALU_ADD = 4'd1;
    localparam logic [3:0] ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;

    typedef enum logic [1:0] {
        CLS_R   = 2'd0,
        CLS_I   = 2'd1,
        CLS_ILL = 2'd2
    } instr_cls_t;

    typedef struct packed {
        logic pc_out;
        logic mar_in;
        logic inc_pc;
        logic pc_in;
        logic read;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
        logic y_in;
        logic c_out;
        logic z_in;
        logic zlow_out;
    } ctrl_t;

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational opcode decoder: maps the IR opcode field to an instruction
// class and the ALU function used in T4.
module alu_seq_decode
    import alu_seq_pkg::*;
#(
    parameter int OPCODE_W = 5,
    parameter int ALU_OP_W = 4
) (
    input  logic [OPCODE_W-1:0] opcode,
    output instr_cls_t          cls,
    output logic [ALU_OP_W-1:0] alu_op
);

    // Opcode lookup; anything outside the map is illegal and gets no ALU function.
    always_comb begin
        cls    = CLS_ILL;
        alu_op = ALU_OP_W'(ALU_NOP);
        case (opcode)
            OPCODE_W'(OP_ADD):  begin cls = CLS_R; alu_op = ALU_OP_W'(ALU_ADD); end
            OPCODE_W'(OP_SUB):  begin cls = CLS_R; alu_op = ALU_OP_W'(ALU_SUB); end
            OPCODE_W'(OP_AND):  begin cls = CLS_R; alu_op = ALU_OP_W'(ALU_AND); end
            OPCODE_W'(OP_OR):   begin cls = CLS_R; alu_op = ALU_OP_W'(ALU_OR);  end
            OPCODE_W'(OP_ADDI): begin cls = CLS_I; alu_op = ALU_OP_W'(ALU_ADD); end
            OPCODE_W'(OP_ANDI): begin cls = CLS_I; alu_op = ALU_OP_W'(ALU_AND); end
            OPCODE_W'(OP_ORI):  begin cls = CLS_I; alu_op = ALU_OP_W'(ALU_OR);  end
            default:            begin cls = CLS_ILL; alu_op = ALU_OP_W'(ALU_NOP); end
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Hardwired fetch/execute sequencer producing datapath strobes per state.
// Optional macro SEQ_SINGLE_STEP_EN adds a Step input gating every advance.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int IR_W     = 32,
    parameter int OPCODE_W = 5,
    parameter int ALU_OP_W = 4,
    parameter int MEM_WAIT = 0
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Run,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                Step,
`endif
    input  logic [IR_W-1:0]     IR,
    output logic                PCout,
    output logic                MARin,
    output logic                IncPC,
    output logic                PCin,
    output logic                Read,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Gra,
    output logic                Grb,
    output logic                Grc,
    output logic                Rin,
    output logic                Rout,
    output logic                Yin,
    output logic                Cout,
    output logic                Zin,
    output logic                Zlowout,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                instr_done,
    output logic                halted,
    output logic [3:0]          state
);

    localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

    state_t                state_r, state_n;
    logic [3:0]            wait_cnt_r, wait_cnt_n;
    instr_cls_t            cls_r, cls_n;
    logic [ALU_OP_W-1:0]   alu_r, alu_n;
    instr_cls_t            dec_cls_s;
    logic [ALU_OP_W-1:0]   dec_alu_s;
    logic                  step_s;
    ctrl_t                 ctrl_s;
    logic [ALU_OP_W-1:0]   alu_op_s;
    logic                  done_s;
    logic                  halted_s;
    logic                  unused_ir_s;

`ifdef SEQ_SINGLE_STEP_EN
    assign step_s = Step;
`else
    assign step_s = 1'b1;
`endif

    // Only the opcode field is consumed; the operand fields feed the datapath.
    assign unused_ir_s = ^IR[IR_W-OPCODE_W-1:0];

    alu_seq_decode #(
        .OPCODE_W (OPCODE_W),
        .ALU_OP_W (ALU_OP_W)
    ) u_decode (
        .opcode (IR[IR_W-1 -: OPCODE_W]),
        .cls    (dec_cls_s),
        .alu_op (dec_alu_s)
    );

    // State, wait counter and latched decode registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_r    <= S_IDLE;
            wait_cnt_r <= 4'd0;
            cls_r      <= CLS_R;
            alu_r      <= ALU_OP_W'(ALU_NOP);
        end else begin
            state_r    <= state_n;
            wait_cnt_r <= wait_cnt_n;
            cls_r      <= cls_n;
            alu_r      <= alu_n;
        end
    end

    // Next-state logic; outside IDLE/HALT every advance is gated by step_s.
    always_comb begin
        state_n    = state_r;
        wait_cnt_n = wait_cnt_r;
        cls_n      = cls_r;
        alu_n      = alu_r;
        case (state_r)
            S_IDLE: begin
                if (Run) state_n = S_T0;
                else     state_n = S_IDLE;
            end
            S_T0: begin
                if (step_s) begin
                    state_n    = S_T1;
                    wait_cnt_n = WAIT_INIT;
                end else begin
                    state_n = S_T0;
                end
            end
            S_T1: begin
                if (!step_s) begin
                    state_n = S_T1;
                end else if (wait_cnt_r == 4'd0) begin
                    state_n = S_T2;
                end else begin
                    wait_cnt_n = wait_cnt_r - 4'd1;
                end
            end
            S_T2: begin
                if (step_s) state_n = S_T3;
                else        state_n = S_T2;
            end
            S_T3: begin
                if (step_s) begin
                    cls_n = dec_cls_s;
                    alu_n = dec_alu_s;
                    if (dec_cls_s == CLS_ILL) state_n = S_HALT;
                    else                      state_n = S_T4;
                end else begin
                    state_n = S_T3;
                end
            end
            S_T4: begin
                if (step_s) state_n = S_T5;
                else        state_n = S_T4;
            end
            S_T5: begin
                if (!step_s)  state_n = S_T5;
                else if (Run) state_n = S_T0;
                else          state_n = S_IDLE;
            end
            S_HALT:  state_n = S_HALT;
            default: state_n = S_IDLE;
        endcase
    end

    // Moore strobe decode; T3 strobes are suppressed when the opcode is illegal.
    always_comb begin
        ctrl_s   = '0;
        alu_op_s = ALU_OP_W'(ALU_NOP);
        done_s   = 1'b0;
        halted_s = 1'b0;
        case (state_r)
            S_IDLE: ctrl_s = '0;
            S_T0: begin
                ctrl_s.pc_out = 1'b1;
                ctrl_s.mar_in = 1'b1;
                ctrl_s.inc_pc = 1'b1;
                ctrl_s.z_in   = 1'b1;
            end
            S_T1: begin
                ctrl_s.zlow_out = 1'b1;
                ctrl_s.pc_in    = 1'b1;
                ctrl_s.read     = 1'b1;
                ctrl_s.mdr_in   = 1'b1;
            end
            S_T2: begin
                ctrl_s.mdr_out = 1'b1;
                ctrl_s.ir_in   = 1'b1;
            end
            S_T3: begin
                if (dec_cls_s != CLS_ILL) begin
                    ctrl_s.grb   = 1'b1;
                    ctrl_s.r_out = 1'b1;
                    ctrl_s.y_in  = 1'b1;
                end else begin
                    ctrl_s = '0;
                end
            end
            S_T4: begin
                alu_op_s    = alu_r;
                ctrl_s.z_in = 1'b1;
                if (cls_r == CLS_R) begin
                    ctrl_s.grc   = 1'b1;
                    ctrl_s.r_out = 1'b1;
                end else begin
                    ctrl_s.c_out = 1'b1;
                end
            end
            S_T5: begin
                ctrl_s.zlow_out = 1'b1;
                ctrl_s.gra      = 1'b1;
                ctrl_s.r_in     = 1'b1;
                done_s          = 1'b1;
            end
            S_HALT:  halted_s = 1'b1;
            default: ctrl_s = '0;
        endcase
    end

    assign PCout      = ctrl_s.pc_out;
    assign MARin      = ctrl_s.mar_in;
    assign IncPC      = ctrl_s.inc_pc;
    assign PCin       = ctrl_s.pc_in;
    assign Read       = ctrl_s.read;
    assign MDRin      = ctrl_s.mdr_in;
    assign MDRout     = ctrl_s.mdr_out;
    assign IRin       = ctrl_s.ir_in;
    assign Gra        = ctrl_s.gra;
    assign Grb        = ctrl_s.grb;
    assign Grc        = ctrl_s.grc;
    assign Rin        = ctrl_s.r_in;
    assign Rout       = ctrl_s.r_out;
    assign Yin        = ctrl_s.y_in;
    assign Cout       = ctrl_s.c_out;
    assign Zin        = ctrl_s.z_in;
    assign Zlowout    = ctrl_s.zlow_out;
    assign alu_op     = alu_op_s;
    assign instr_done = done_s;
    assign halted     = halted_s;
    assign state      = state_r;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench: three sequencers (MEM_WAIT 0, 2, 3) driven in parallel,
// checked every cycle against a cycle-index model plus directed literal checks.
module tb_alu_seq_ctrl;
    import alu_seq_pkg::*;

    // Bit positions inside the packed observation vector.
    localparam int B_PCOUT = 22, B_MARIN = 21, B_INCPC = 20, B_PCIN = 19;
    localparam int B_READ = 18, B_MDRIN = 17, B_MDROUT = 16, B_IRIN = 15;
    localparam int B_GRA = 14, B_GRB = 13, B_GRC = 12, B_RIN = 11;
    localparam int B_ROUT = 10, B_YIN = 9, B_COUT = 8, B_ZIN = 7, B_ZLOW = 6;
    localparam int B_DONE = 1, B_HALT = 0;

    logic        Clock;
    logic        Reset;
    logic        Run;
    logic        Step;
    logic [31:0] IR;

    logic [26:0] act [3];

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
        logic pcout, marin, incpc, pcin, rd, mdrin, mdrout, irin;
        logic gra, grb, grc, rin, rout, yin, cout, zin, zlow;
        logic [3:0] alu, st;
        logic done, hlt;

        alu_seq_ctrl #(.IR_W(32), .OPCODE_W(5), .ALU_OP_W(4), .MEM_WAIT(W)) dut (
            .Clock(Clock), .Reset(Reset), .Run(Run),
`ifdef SEQ_SINGLE_STEP_EN
            .Step(Step),
`endif
            .IR(IR),
            .PCout(pcout), .MARin(marin), .IncPC(incpc), .PCin(pcin),
            .Read(rd), .MDRin(mdrin), .MDRout(mdrout), .IRin(irin),
            .Gra(gra), .Grb(grb), .Grc(grc), .Rin(rin), .Rout(rout),
            .Yin(yin), .Cout(cout), .Zin(zin), .Zlowout(zlow),
            .alu_op(alu), .instr_done(done), .halted(hlt), .state(st)
        );

        assign act[g] = {st, pcout, marin, incpc, pcin, rd, mdrin, mdrout, irin,
                         gra, grb, grc, rin, rout, yin, cout, zin, zlow,
                         alu, done, hlt};
    end

    function automatic int wt(int i);
        return (i == 0) ? 0 : ((i == 1) ? 2 : 3);
    endfunction

    // 0 = register-register, 1 = register-immediate, 2 = illegal.
    function automatic int op_kind(logic [4:0] opc);
        case (opc)
            5'b00011, 5'b00100, 5'b01010, 5'b01011: return 0;
            5'b01100, 5'b01101, 5'b01110:           return 1;
            default:                                return 2;
        endcase
    endfunction

    function automatic logic [3:0] op_alu(logic [4:0] opc);
        case (opc)
            5'b00011, 5'b01100: return ALU_ADD;
            5'b00100:           return ALU_SUB;
            5'b01010, 5'b01101: return ALU_AND;
            5'b01011, 5'b01110: return ALU_OR;
            default:            return ALU_NOP;
        endcase
    endfunction

    // Model: mode 0 idle, 1 running at cycle index k of the instruction, 2 halted.
    int         m_mode [3] = '{0, 0, 0};
    int         m_k    [3] = '{0, 0, 0};
    logic       m_rtype[3] = '{1'b0, 1'b0, 1'b0};
    logic [3:0] m_alu  [3] = '{4'd0, 4'd0, 4'd0};

    function automatic logic [26:0] model_vec(int mode, int k, int w, logic rtype,
                                              logic [3:0] alu, logic [4:0] opc);
        logic [26:0] v;
        int p;
        v = '0;
        v[26:23] = ST_IDLE;
        if (mode == 2) begin
            v[26:23] = ST_HALT;
            v[B_HALT] = 1'b1;
        end else if (mode == 1) begin
            if (k == 0)          p = 0;
            else if (k <= 1 + w) p = 1;
            else                 p = k - w;
            case (p)
                0: begin v[26:23] = ST_T0; v[B_PCOUT] = 1'b1; v[B_MARIN] = 1'b1;
                         v[B_INCPC] = 1'b1; v[B_ZIN] = 1'b1; end
                1: begin v[26:23] = ST_T1; v[B_ZLOW] = 1'b1; v[B_PCIN] = 1'b1;
                         v[B_READ] = 1'b1; v[B_MDRIN] = 1'b1; end
                2: begin v[26:23] = ST_T2; v[B_MDROUT] = 1'b1; v[B_IRIN] = 1'b1; end
                3: begin
                    v[26:23] = ST_T3;
                    if (op_kind(opc) != 2) begin
                        v[B_GRB] = 1'b1; v[B_ROUT] = 1'b1; v[B_YIN] = 1'b1;
                    end
                end
                4: begin
                    v[26:23] = ST_T4; v[5:2] = alu; v[B_ZIN] = 1'b1;
                    if (rtype) begin v[B_GRC] = 1'b1; v[B_ROUT] = 1'b1; end
                    else       v[B_COUT] = 1'b1;
                end
                default: begin v[26:23] = ST_T5; v[B_ZLOW] = 1'b1; v[B_GRA] = 1'b1;
                               v[B_RIN] = 1'b1; v[B_DONE] = 1'b1; end
            endcase
        end
        return v;
    endfunction

    always @(posedge Clock or posedge Reset) begin
        for (int i = 0; i < 3; i++) begin
            if (Reset) begin
                m_mode[i] <= 0;
                m_k[i]    <= 0;
            end else if (m_mode[i] == 0) begin
                if (Run) begin m_mode[i] <= 1; m_k[i] <= 0; end
            end else if (m_mode[i] == 1 && Step) begin
                if (m_k[i] == 5 + wt(i)) begin
                    if (Run) m_k[i] <= 0;
                    else     m_mode[i] <= 0;
                end else if (m_k[i] == 3 + wt(i) && op_kind(IR[31:27]) == 2) begin
                    m_mode[i] <= 2;
                end else begin
                    if (m_k[i] == 3 + wt(i)) begin
                        m_rtype[i] <= (op_kind(IR[31:27]) == 0);
                        m_alu[i]   <= op_alu(IR[31:27]);
                    end
                    m_k[i] <= m_k[i] + 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, a, e, $time);
        end
    endtask

    // Per-cycle comparison of every instance against the model.
    always @(negedge Clock) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++)
                check($sformatf("model_w%0d", wt(i)), 32'(act[i]),
                      32'(model_vec(m_mode[i], m_k[i], wt(i), m_rtype[i], m_alu[i], IR[31:27])));
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic drain(input int n);
        for (int j = 0; j < n; j++) tick();
    endtask

    initial begin
        int rd_cnt, rd_first, rd_last, done_cyc;
        Reset = 1'b1; Run = 1'b0; Step = 1'b1; IR = 32'h0;
        drain(2);
        chk_en = 1'b1;
        check("reset_w0", 32'(act[0]), 32'h0);
        check("reset_w3", 32'(act[2]), 32'h0);
        Reset = 1'b0;
        tick();

        // addi, single-cycle memory
        IR = 32'h611F_FFFD; Run = 1'b1;
        tick();
        Run = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c == 1) check("addi_t0_state", 32'(act[0][26:23]), 32'd1);
            if (c == 5) begin
                check("addi_t4_cout_zin_grc", {29'd0, act[0][B_COUT], act[0][B_ZIN], act[0][B_GRC]}, 32'b110);
                check("addi_t4_aluop", 32'(act[0][5:2]), 32'd1);
                check("addi_no_done_c5", 32'(act[0][B_DONE]), 32'd0);
            end
            if (c == 6) check("addi_done_c6", 32'(act[0][B_DONE]), 32'd1);
            tick();
        end
        check("addi_idle_after", 32'(act[0][26:23]), 32'd0);
        drain(6);

        // sub, two memory wait states on instance 1
        IR = {5'b00100, 27'd0}; Run = 1'b1;
        tick();
        Run = 1'b0;
        rd_cnt = 0; rd_first = 0; rd_last = 0; done_cyc = 0;
        for (int c = 1; c <= 10; c++) begin
            if (act[1][B_READ] && act[1][B_MDRIN]) begin
                rd_cnt++;
                if (rd_first == 0) rd_first = c;
                rd_last = c;
            end
            if (act[1][B_DONE] && done_cyc == 0) done_cyc = c;
            if (c == 7) begin
                check("sub_t4_grc_rout", {30'd0, act[1][B_GRC], act[1][B_ROUT]}, 32'b11);
                check("sub_t4_aluop", 32'(act[1][5:2]), 32'd2);
            end
            tick();
        end
        check("sub_read_count", 32'(rd_cnt), 32'd3);
        check("sub_read_window", {16'(rd_first), 16'(rd_last)}, {16'd2, 16'd4});
        check("sub_done_cycle", 32'(done_cyc), 32'd8);
        drain(4);

        // back-to-back addi, Run dropped during the second T2
        IR = 32'h611F_FFFD; Run = 1'b1;
        tick();
        for (int c = 1; c <= 13; c++) begin
            if (c == 9) Run = 1'b0;
            if (c == 6)  check("b2b_t5_state", 32'(act[0][26:23]), 32'd6);
            if (c == 7)  check("b2b_direct_t0", 32'(act[0][26:23]), 32'd1);
            if (c == 12) check("b2b_second_t5", 32'(act[0][26:23]), 32'd6);
            if (c == 13) check("b2b_idle", 32'(act[0][26:23]), 32'd0);
            tick();
        end
        drain(12);

        // reset two cycles into a 4-cycle T1
        Run = 1'b1;
        tick();
        Run = 1'b0;
        drain(2);
        check("midT1_state", 32'(act[2][26:23]), 32'd2);
        check("midT1_read", 32'(act[2][B_READ]), 32'd1);
        #1 Reset = 1'b1;
        #1 check("midT1_async_clear", 32'(act[2]), 32'h0);
        #1 Reset = 1'b0;
        tick();
        Run = 1'b1;
        tick();
        Run = 1'b0;
        check("midT1_restart_t0", 32'(act[2][26:23]), 32'd1);
        drain(12);

        // illegal opcode halts; Run activity is ignored
        IR = 32'hF800_0000; Run = 1'b1;
        tick();
        for (int c = 1; c <= 14; c++) begin
            Run = c[0];
            tick();
        end
        for (int i = 0; i < 3; i++)
            check($sformatf("halt_w%0d", wt(i)), {27'd0, act[i][26:23], act[i][B_HALT]}, {27'd0, 4'd7, 1'b1});
        Run = 1'b0;
        #1 Reset = 1'b1;
        #1 check("halt_cleared", {27'd0, act[0][26:23], act[0][B_HALT]}, 32'd0);
        #1 Reset = 1'b0;
        tick();

`ifdef SEQ_SINGLE_STEP_EN
        // hold in T2 with Step low
        IR = 32'h611F_FFFD; Run = 1'b1;
        tick();
        Run = 1'b0;
        drain(2);
        check("step_in_t2", 32'(act[0][26:23]), 32'd3);
        Step = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("step_hold_t2", {27'd0, act[0][26:23], act[0][B_MDROUT] & act[0][B_IRIN]}, {27'd0, 4'd3, 1'b1});
        end
        Step = 1'b1;
        tick();
        check("step_adv_t3", 32'(act[0][26:23]), 32'd4);
        drain(12);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
